dds_phase_accumulator_module: RTL and testbench



---
 rtl/dds_phase_accumulator_module_pkg.sv | 7 +
 rtl/dds_quadrant_fold_module.sv | 29 ++
 rtl/dds_phase_accumulator_module.sv | 60 ++++++
 tb/tb_dds_phase_accumulator_module.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dds_phase_accumulator_module_pkg.sv
// dds_phase_accumulator_module_pkg: shared constants and quadrant encoding for the DDS phase path
package dds_phase_accumulator_module_pkg;
    localparam logic [7:0] DAC_MID = 8'h80;
    localparam int KW_RESET_DEFAULT = 5;
    localparam int ROM_LAT = 1;
    typedef enum logic [1:0] {Q0 = 2'd0, Q1 = 2'd1, Q2 = 2'd2, Q3 = 2'd3} quad_t;
endpackage

// File: rtl/dds_quadrant_fold_module.sv
// dds_quadrant_fold_module: folds a full-wave index into a quarter-wave ROM address and delays the quadrant
module dds_quadrant_fold_module
    import dds_phase_accumulator_module_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] idx,
    output logic [ADDR_W-3:0] addr,
    output quad_t             quad
);
    // Quadrant travels one stage for the fold register plus the ROM read latency
    localparam int D = ROM_LAT + 1;
    quad_t q_in;
    quad_t q_pipe [D];
    assign q_in = quad_t'(idx[ADDR_W-1:ADDR_W-2]);
    assign quad = q_pipe[D-1];
    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
            for (int i = 0; i < D; i++) q_pipe[i] <= Q0;
        end else begin
            addr <= q_in[0] ? ~idx[ADDR_W-3:0] : idx[ADDR_W-3:0];
            q_pipe[0] <= q_in;
            for (int i = 1; i < D; i++) q_pipe[i] <= q_pipe[i-1];
        end
    end
endmodule

// File: rtl/dds_phase_accumulator_module.sv
// dds_phase_accumulator_module: phase accumulator with wrap-synchronous word update and full-wave sine rebuild
module dds_phase_accumulator_module
    import dds_phase_accumulator_module_pkg::*;
#(
    parameter int PHASE_W     = 20,
    parameter int KW_W        = 12,
    parameter int ADDR_W      = 10,
    parameter int KW_RESET    = KW_RESET_DEFAULT,
    parameter int SYNC_UPDATE = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Enable,
    input  logic              Phase_Clr,
    input  logic [KW_W-1:0]   KW_In,
    output logic [ADDR_W-3:0] ROM_Addr_Out,
    input  logic [6:0]        ROM_Data_In,
    output logic [7:0]        DAC_Out,
    output logic              Sync_Out,
    output logic              Valid_Out
);
    logic [PHASE_W-1:0] phase;
    logic [KW_W-1:0]    kw_active;
    logic [PHASE_W:0]   sum;
    logic [2:0]         valid_sr;
    logic               wrap;
    quad_t              quad;
    assign sum = {1'b0, phase} + {{(PHASE_W+1-KW_W){1'b0}}, kw_active};
    assign wrap = Enable & sum[PHASE_W];
    assign Valid_Out = valid_sr[2];
    always_ff @(posedge CLK) begin
        if (RST) begin
            phase     <= '0;
            kw_active <= KW_W'(KW_RESET);
            Sync_Out  <= 1'b0;
            valid_sr  <= '0;
            DAC_Out   <= DAC_MID;
        end else begin
            valid_sr <= {valid_sr[1:0], 1'b1};
            DAC_Out  <= quad[1] ? DAC_MID - {1'b0, ROM_Data_In} : DAC_MID + {1'b0, ROM_Data_In};
            if (Phase_Clr) begin
                phase     <= '0;
                kw_active <= KW_In;
                Sync_Out  <= 1'b0;
            end else begin
                if (Enable) phase <= sum[PHASE_W-1:0];
                Sync_Out <= wrap;
                // A new word only lands on a wrap so the output period never glitches
                if (SYNC_UPDATE == 0 || wrap) kw_active <= KW_In;
            end
        end
    end
    dds_quadrant_fold_module #(.ADDR_W(ADDR_W)) u_fold (
        .clk (CLK),
        .rst (RST),
        .idx (phase[PHASE_W-1 -: ADDR_W]),
        .addr(ROM_Addr_Out),
        .quad(quad)
    );
endmodule

// File: tb/tb_dds_phase_accumulator_module.sv
// tb_dds_phase_accumulator_module: vector table plus scoreboard checks of the DDS phase path
module tb_dds_phase_accumulator_module;
    localparam int PW = 12, AW = 10, KW = 12;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic [KW-1:0] kw = 12'd5;
    logic [AW-3:0] addr1, addr0;
    logic [6:0] rom1, rom0;
    logic [7:0] dac1, dac0;
    logic sync1, sync0, val1, val0;
    int total = 0, bad = 0;
    logic [PW-1:0] m_ph, m_ph0;
    logic [KW-1:0] m_kw, m_kw0;
    logic m_sync, m_sync0;
    logic [AW-3:0] m_addr;
    int m_vcnt;
    logic [7:0] sb[$], sb0[$];
    typedef struct {
        logic r, e, c;
        logic [KW-1:0] k;
        logic [PW-1:0] ph;
        logic v, s;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        rom1 <= addr1[AW-3:1];
        rom0 <= addr0[AW-3:1];
    end

    dds_phase_accumulator_module #(.PHASE_W(PW), .KW_W(KW), .ADDR_W(AW), .KW_RESET(5), .SYNC_UPDATE(1)) dut (
        .CLK(clk), .RST(rst), .Enable(en), .Phase_Clr(clr), .KW_In(kw),
        .ROM_Addr_Out(addr1), .ROM_Data_In(rom1), .DAC_Out(dac1), .Sync_Out(sync1), .Valid_Out(val1));

    dds_phase_accumulator_module #(.PHASE_W(PW), .KW_W(KW), .ADDR_W(AW), .KW_RESET(5), .SYNC_UPDATE(0)) dut0 (
        .CLK(clk), .RST(rst), .Enable(en), .Phase_Clr(clr), .KW_In(kw),
        .ROM_Addr_Out(addr0), .ROM_Data_In(rom0), .DAC_Out(dac0), .Sync_Out(sync0), .Valid_Out(val0));

    function automatic logic [AW-3:0] fold(input logic [PW-1:0] p);
        logic [AW-1:0] idx;
        idx = p[PW-1 -: AW];
        return idx[AW-2] ? ~idx[AW-3:0] : idx[AW-3:0];
    endfunction

    function automatic logic [7:0] exp_dac(input logic [PW-1:0] p);
        logic [AW-3:0] a;
        logic [7:0] r;
        a = fold(p);
        r = {1'b0, a[AW-3:1]};
        return p[PW-1] ? 8'h80 - r : 8'h80 + r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic c, input logic [KW-1:0] k);
        logic [PW:0] s, s0;
        rst = r; en = e; clr = c; kw = k;
        @(posedge clk);
        if (r) begin
            m_ph = '0; m_kw = 12'd5; m_ph0 = '0; m_kw0 = 12'd5;
            m_sync = 1'b0; m_sync0 = 1'b0; m_vcnt = 0; m_addr = '0;
            sb.delete(); sb0.delete();
            repeat (3) begin sb.push_back(8'h80); sb0.push_back(8'h80); end
        end else begin
            m_addr = fold(m_ph);
            if (m_vcnt < 3) m_vcnt++;
            if (c) begin
                m_ph = '0; m_kw = k; m_sync = 1'b0;
                m_ph0 = '0; m_kw0 = k; m_sync0 = 1'b0;
            end else begin
                s = {1'b0, m_ph} + {1'b0, m_kw};
                s0 = {1'b0, m_ph0} + {1'b0, m_kw0};
                m_sync = e & s[PW];
                m_sync0 = e & s0[PW];
                if (e) begin
                    m_ph = s[PW-1:0];
                    m_ph0 = s0[PW-1:0];
                end
                if (e && s[PW]) m_kw = k;
                m_kw0 = k;
            end
        end
        sb.push_back(exp_dac(m_ph));
        sb0.push_back(exp_dac(m_ph0));
        @(negedge clk);
        chk("phase", 32'(dut.phase), 32'(m_ph));
        chk("phase0", 32'(dut0.phase), 32'(m_ph0));
        chk("sync", 32'(sync1), 32'(m_sync));
        chk("sync0", 32'(sync0), 32'(m_sync0));
        chk("valid", 32'(val1), 32'(m_vcnt >= 3));
        chk("valid0", 32'(val0), 32'(m_vcnt >= 3));
        chk("addr", 32'(addr1), 32'(m_addr));
        chk("dac", 32'(dac1), 32'(sb.pop_front()));
        chk("dac0", 32'(dac0), 32'(sb0.pop_front()));
    endtask

    initial begin
        int n;
        logic [PW-1:0] p;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 12'd5, 12'd0,  1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 12'd5, 12'd0,  1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 12'd5, 12'd5,  1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 12'd5, 12'd10, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 12'd5, 12'd15, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].k);
            chk("tbl_phase", 32'(dut.phase), 32'(tbl[i].ph));
            chk("tbl_valid", 32'(val1), 32'(tbl[i].v));
            chk("tbl_sync", 32'(sync1), 32'(tbl[i].s));
            chk("tbl_dac", 32'(dac1), 32'h80);
        end
        // quarter-period word: one wrap every 4 cycles
        step(1'b0, 1'b0, 1'b1, 12'd1024);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 12'd1024);
            if (sync1) n++;
        end
        chk("sync_count_1024", 32'(n), 32'd2);
        // word change only takes effect at the wrap
        step(1'b0, 1'b0, 1'b1, 12'd4000);
        step(1'b0, 1'b1, 1'b0, 12'd4000);
        step(1'b0, 1'b1, 1'b0, 12'd5);
        chk("wrap_3904", 32'(dut.phase), 32'd3904);
        n = 0;
        do begin
            step(1'b0, 1'b1, 1'b0, 12'd9);
            n++;
        end while (!sync1 && n < 60);
        chk("wrap_found", 32'(sync1), 32'd1);
        chk("wrap_steps_of_5", 32'(n), 32'd39);
        p = dut.phase;
        step(1'b0, 1'b1, 1'b0, 12'd9);
        chk("step9", 32'(PW'(dut.phase - p)), 32'd9);
        // clear while disabled
        step(1'b0, 1'b0, 1'b1, 12'd700);
        step(1'b0, 1'b1, 1'b0, 12'd700);
        chk("phase700", 32'(dut.phase), 32'd700);
        step(1'b0, 1'b0, 1'b1, 12'd5);
        chk("clr_phase", 32'(dut.phase), 32'd0);
        chk("clr_sync", 32'(sync1), 32'd0);
        repeat (5) step(1'b0, 1'b0, 1'b0, 12'd5);
        chk("hold_dac", 32'(dac1), 32'h80);
        // zero word after a wrap freezes the phase
        step(1'b0, 1'b0, 1'b1, 12'd2048);
        step(1'b0, 1'b1, 1'b0, 12'd0);
        step(1'b0, 1'b1, 1'b0, 12'd0);
        chk("kw0_wrap", 32'(sync1), 32'd1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 12'd0);
            if (sync1) n++;
        end
        chk("kw0_syncs", 32'(n), 32'd0);
        chk("kw0_phase", 32'(dut.phase), 32'd0);
        chk("kw0_dac", 32'(dac1), 32'h80);
        // reset in the middle of a sweep
        step(1'b0, 1'b0, 1'b1, 12'd300);
        step(1'b0, 1'b1, 1'b0, 12'd300);
        step(1'b0, 1'b1, 1'b0, 12'd300);
        step(1'b1, 1'b1, 1'b0, 12'd77);
        chk("rst_dac", 32'(dac1), 32'h80);
        chk("rst_valid", 32'(val1), 32'd0);
        chk("rst_addr", 32'(addr1), 32'd0);
        chk("rst_phase", 32'(dut.phase), 32'd0);
        step(1'b1, 1'b1, 1'b0, 12'd77);
        step(1'b0, 1'b1, 1'b0, 12'd77);
        chk("rst_kw_default", 32'(dut.phase), 32'd5);
        chk("rst_kw_default0", 32'(dut0.phase), 32'd5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
